// File: rtl/multiport_ram_if.sv
// Lane bus and clear-engine bus of the shared multi-lane RAM.
// Lane i occupies slice i of every packed vector, lane 0 in the LSBs.
interface multiport_ram_if #(
  parameter int DATA_LEN    = 16,
  parameter int ADDRESS_LEN = 8,
  parameter int NUM_PORTS   = 3
);
  logic [NUM_PORTS-1:0]             rd_en;
  logic [NUM_PORTS-1:0]             wr_en;
  logic [ADDRESS_LEN*NUM_PORTS-1:0] address;
  logic [DATA_LEN*NUM_PORTS-1:0]    data_in;
  logic [DATA_LEN*NUM_PORTS-1:0]    data_out;
  logic [NUM_PORTS-1:0]             rd_valid;
  logic [NUM_PORTS-1:0]             wr_conflict;
  logic [15:0]                      conflict_cnt;
  logic                             clr_start;
  logic [ADDRESS_LEN-1:0]           clr_base;
  logic [ADDRESS_LEN:0]             clr_count;
  logic                             busy;
  logic                             clr_done;

  modport master (
    output rd_en, wr_en, address, data_in, clr_start, clr_base, clr_count,
    input  data_out, rd_valid, wr_conflict, conflict_cnt, busy, clr_done
  );

  modport slave (
    input  rd_en, wr_en, address, data_in, clr_start, clr_base, clr_count,
    output data_out, rd_valid, wr_conflict, conflict_cnt, busy, clr_done
  );
endinterface

// File: rtl/multiport_ram.sv
// Shared RAM with NUM_PORTS read/write lanes, lowest-lane-wins write arbitration
// and a background range-clear engine. All reads are read-first with one cycle latency.
module multiport_ram #(
  parameter int    DATA_LEN    = 16,
  parameter int    ADDRESS_LEN = 8,
  parameter int    NUM_PORTS   = 3,
  parameter string INIT_FILE   = ""
) (
  input logic            clk,
  input logic            rst_n,
  multiport_ram_if.slave bus
);

  localparam int DEPTH = 1 << ADDRESS_LEN;
  localparam logic [ADDRESS_LEN:0]   CNT_ZERO  = {(ADDRESS_LEN+1){1'b0}};
  localparam logic [ADDRESS_LEN:0]   CNT_ONE   = {{ADDRESS_LEN{1'b0}}, 1'b1};
  localparam logic [ADDRESS_LEN-1:0] PTR_ONE   = {{(ADDRESS_LEN-1){1'b0}}, 1'b1};
  localparam logic [DATA_LEN-1:0]    WORD_ZERO = {DATA_LEN{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_DONE  = 2'd2
  } clr_state_e;

  logic [DATA_LEN-1:0]           mem_r [DEPTH];
  clr_state_e                    state_r;
  clr_state_e                    state_next_s;
  logic [ADDRESS_LEN-1:0]        ptr_r;
  logic [ADDRESS_LEN:0]          remain_r;
  logic                          busy_r;
  logic                          clr_done_r;
  logic [DATA_LEN*NUM_PORTS-1:0] data_out_r;
  logic [NUM_PORTS-1:0]          rd_valid_r;
  logic [NUM_PORTS-1:0]          wr_conflict_r;
  logic [15:0]                   conflict_cnt_r;
  logic [NUM_PORTS-1:0]          coll_s;
  logic [NUM_PORTS-1:0]          lose_s;
  logic [NUM_PORTS-1:0]          win_s;
  logic [3:0]                    lose_cnt_s;
  logic [16:0]                   cnt_sum_s;
  logic [15:0]                   cnt_next_s;

  // True when some lower-numbered lane writes the same address as `lane`.
  function automatic logic lower_lane_hit(
    input int                             lane,
    input logic [NUM_PORTS-1:0]           wr,
    input logic [ADDRESS_LEN*NUM_PORTS-1:0] addr
  );
    logic hit;
    hit = 1'b0;
    for (int j = 0; j < NUM_PORTS; j++) begin
      hit = hit | ((j < lane) & wr[j] &
                   (addr[ADDRESS_LEN*j +: ADDRESS_LEN] == addr[ADDRESS_LEN*lane +: ADDRESS_LEN]));
    end
    return hit;
  endfunction

  function automatic logic [3:0] popcount(input logic [NUM_PORTS-1:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

  // Write arbitration: lowest lane wins; while the clear engine runs every lane write is dropped uncounted.
  always_comb begin
    coll_s = {NUM_PORTS{1'b0}};
    for (int i = 0; i < NUM_PORTS; i++) begin
      coll_s[i] = bus.wr_en[i] & lower_lane_hit(i, bus.wr_en, bus.address);
    end
    lose_s     = coll_s & {NUM_PORTS{~busy_r}};
    win_s      = bus.wr_en & ~coll_s & {NUM_PORTS{~busy_r}};
    lose_cnt_s = popcount(lose_s);
    cnt_sum_s  = {1'b0, conflict_cnt_r} + {13'd0, lose_cnt_s};
    cnt_next_s = cnt_sum_s[16] ? 16'hFFFF : cnt_sum_s[15:0];
  end

  // Clear engine next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.clr_start) begin
          state_next_s = (bus.clr_count == CNT_ZERO) ? ST_DONE : ST_CLEAR;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        if (remain_r == CNT_ONE) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_CLEAR;
        end
      end
      ST_DONE: state_next_s = ST_IDLE;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Clear engine state, pointer and status flags (flags follow the next state so they line up with it).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      ptr_r      <= {ADDRESS_LEN{1'b0}};
      remain_r   <= CNT_ZERO;
      busy_r     <= 1'b0;
      clr_done_r <= 1'b0;
    end else begin
      state_r    <= state_next_s;
      busy_r     <= (state_next_s != ST_IDLE);
      clr_done_r <= (state_next_s == ST_DONE);
      if ((state_r == ST_IDLE) && bus.clr_start) begin
        ptr_r    <= bus.clr_base;
        remain_r <= bus.clr_count;
      end else if (state_r == ST_CLEAR) begin
        ptr_r    <= ptr_r + PTR_ONE;
        remain_r <= remain_r - CNT_ONE;
      end else begin
        ptr_r    <= ptr_r;
        remain_r <= remain_r;
      end
    end
  end

  // Memory array: never reset, so a clear cut short by reset stays partial.
  always_ff @(posedge clk) begin
    if (state_r == ST_CLEAR) begin
      mem_r[ptr_r] <= WORD_ZERO;
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (win_s[i]) begin
          mem_r[bus.address[ADDRESS_LEN*i +: ADDRESS_LEN]] <= bus.data_in[DATA_LEN*i +: DATA_LEN];
        end
      end
    end
  end

  // Lane read data, valid pulses and conflict reporting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out_r     <= {(DATA_LEN*NUM_PORTS){1'b0}};
      rd_valid_r     <= {NUM_PORTS{1'b0}};
      wr_conflict_r  <= {NUM_PORTS{1'b0}};
      conflict_cnt_r <= 16'h0000;
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (bus.rd_en[i]) begin
          data_out_r[DATA_LEN*i +: DATA_LEN] <= mem_r[bus.address[ADDRESS_LEN*i +: ADDRESS_LEN]];
        end
      end
      rd_valid_r     <= bus.rd_en;
      wr_conflict_r  <= lose_s;
      conflict_cnt_r <= cnt_next_s;
    end
  end

  assign bus.data_out     = data_out_r;
  assign bus.rd_valid     = rd_valid_r;
  assign bus.wr_conflict  = wr_conflict_r;
  assign bus.conflict_cnt = conflict_cnt_r;
  assign bus.busy         = busy_r;
  assign bus.clr_done     = clr_done_r;

endmodule
